// File: rtl/spi_seq_pkg.sv
// Shared types and helpers for the SPI transfer sequencer: FSM states,
// frame-length decode and edge counter sizing.
package spi_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_HOLD
  } state_e;

  // Edge index runs 0..2N-1, at most 63 for a 32-bit frame.
  localparam int EDGE_W = 6;

  function automatic logic [EDGE_W-1:0] frame_bits(input logic [1:0] dtb);
    return {1'b0, dtb, 3'b000} + 6'd8;
  endfunction

  // Index of the final SCK edge of a frame, 2N-1.
  function automatic logic [EDGE_W-1:0] last_edge(input logic [1:0] dtb);
    logic [EDGE_W-1:0] n;
    n = frame_bits(dtb);
    return EDGE_W'({n, 1'b0} - 7'd1);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Loadable half-period counter: ticks when the count reaches div_i, then wraps.
// One extra bit of headroom keeps an all-ones divider from aliasing.
module spi_clk_div #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic [W-1:0] div_i,
  output logic         tick_o
);

  logic [W:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == {1'b0, div_i});

  always_comb begin
    cnt_d = cnt_q + (W+1)'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_xfer_seq.sv
// SPI master transfer sequencer: frames NSS, generates SCK from the divider and
// strobes the shift-register datapath (load/shift/sample). All outputs registered.
module spi_xfer_seq
  import spi_seq_pkg::*;
#(
  parameter int DIV_WIDTH = 16,
  parameter int NSS_NUM   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 start_i,
  input  logic                 cpol_i,
  input  logic                 cpha_i,
  input  logic                 ass_i,
  input  logic [1:0]           dtb_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic [NSS_NUM-1:0]   nss_i,
  output logic                 sck_o,
  output logic [NSS_NUM-1:0]   nss_o,
  output logic                 load_o,
  output logic                 shift_o,
  output logic                 sample_o,
  output logic                 busy_o,
  output logic                 done_o
);

  state_e                state_q, state_d;
  logic                  sck_q, sck_d;
  logic [NSS_NUM-1:0]    nss_q, nss_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  load_q, load_d;
  logic                  shift_q, shift_d;
  logic                  sample_q, sample_d;
  logic [EDGE_W-1:0]     edge_q, edge_d;
  logic [EDGE_W-1:0]     last_q, last_d;
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;
  logic                  ass_q, ass_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic                  tick;
  logic                  div_clr;

  // The half-period count restarts on every state change and is parked in IDLE.
  assign div_clr = (state_d != state_q) || (state_q == ST_IDLE);

  spi_clk_div #(.W(DIV_WIDTH)) u_clk_div (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (div_clr),
    .div_i  (div_q),
    .tick_o (tick)
  );

  always_comb begin
    state_d  = state_q;
    sck_d    = sck_q;
    nss_d    = nss_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    load_d   = 1'b0;
    shift_d  = 1'b0;
    sample_d = 1'b0;
    edge_d   = edge_q;
    last_d   = last_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    ass_d    = ass_q;
    div_d    = div_q;

    case (state_q)
      ST_IDLE: begin
        sck_d  = cpol_i;
        nss_d  = ass_i ? '1 : nss_i;
        busy_d = 1'b0;
        edge_d = '0;
        if (start_i && en_i) begin
          state_d = ST_SETUP;
          busy_d  = 1'b1;
          load_d  = 1'b1;
          nss_d   = ass_i ? '0 : nss_i;
          cpol_d  = cpol_i;
          cpha_d  = cpha_i;
          ass_d   = ass_i;
          div_d   = div_i;
          last_d  = last_edge(dtb_i);
        end
      end
      ST_SETUP: begin
        if (!ass_q) nss_d = nss_i;
        if (tick) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (!ass_q) nss_d = nss_i;
        if (tick) begin
          sck_d = ~sck_q;
          // Even edge index = leading edge, odd = trailing edge.
          sample_d = cpha_q ? edge_q[0] : ~edge_q[0];
          shift_d  = cpha_q ? ~edge_q[0] : (edge_q[0] && (edge_q != last_q));
          if (edge_q == last_q) begin
            state_d = ST_HOLD;
            edge_d  = '0;
          end else begin
            edge_d = edge_q + EDGE_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (!ass_q) nss_d = nss_i;
        if (tick) begin
          state_d = ST_IDLE;
          sck_d   = cpol_q;
          nss_d   = ass_q ? '1 : nss_i;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Disable wins over everything: drop the frame silently.
    if ((state_q != ST_IDLE) && !en_i) begin
      state_d  = ST_IDLE;
      sck_d    = cpol_i;
      nss_d    = ass_i ? '1 : nss_i;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      shift_d  = 1'b0;
      sample_d = 1'b0;
      edge_d   = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      sck_q    <= 1'b0;
      nss_q    <= '1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      load_q   <= 1'b0;
      shift_q  <= 1'b0;
      sample_q <= 1'b0;
      edge_q   <= '0;
      last_q   <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      ass_q    <= 1'b0;
      div_q    <= '0;
    end else begin
      state_q  <= state_d;
      sck_q    <= sck_d;
      nss_q    <= nss_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      load_q   <= load_d;
      shift_q  <= shift_d;
      sample_q <= sample_d;
      edge_q   <= edge_d;
      last_q   <= last_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      ass_q    <= ass_d;
      div_q    <= div_d;
    end
  end

  assign sck_o    = sck_q;
  assign nss_o    = nss_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign load_o   = load_q;
  assign shift_o  = shift_q;
  assign sample_o = sample_q;

endmodule
